mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

Two-port arbiter sharing the single-port 1024x32 unified memory of the mips32 core between the instruction-fetch requester (IF stage) and the data requester (LW/SW in EX/WB). It accepts a req/gnt handshake from each requester and issues one memory access at a time. Read data returns one cycle after the access. By default it uses data-first priority with a starvation guard for fetch.

## Interface
- AW, 10, memory word-address width (1024 words)
- DW, 32, data width
- MAX_WAIT, 3, consecutive lost arbitrations after which fetch is forced to win (1..15)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request, held until if_gnt
- if_addr  input  AW  fetch word address, stable while if_req
- if_gnt  output  1  one-cycle pulse, fetch access issued this cycle
- if_rvalid  output  1  one-cycle pulse, if_rdata valid
- if_rdata  output  DW  fetch read data
- d_req  input  1  data request, held until d_gnt
- d_we  input  1  1 = store (SW), 0 = load (LW)
- d_addr  input  AW  data word address
- d_wdata  input  DW  store data
- d_gnt  output  1  one-cycle pulse, data access issued this cycle
- d_rvalid  output  1  one-cycle pulse for loads only
- d_rdata  output  DW  load read data
- mem_en, mem_we  output  1  memory enable / write enable
- mem_addr  output  AW  memory address (registered)
- mem_wdata  output  DW  memory write data (registered)
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- States: IDLE, ACCESS.
- IDLE: arbitrate on sampled if_req and d_req. On a winner: latch its addr, we (fetch: 0) and wdata into mem_* registers, record the owner, and go to ACCESS. With no request, stay in IDLE.
- ACCESS: mem_en=1 and the owner's gnt=1 for exactly this cycle; return to IDLE unconditionally.
- Response: on the cycle after ACCESS, if the access was a read, the owner's rvalid=1 and its rdata = mem_rdata. No rvalid for stores.
- Priority (default): d_req wins over if_req. Counter if_wait (4 bits) increments on each IDLE arbitration where if_req=1 and fetch loses. It clears when fetch is granted or when if_req=0. When if_wait == MAX_WAIT, fetch wins regardless of d_req.
- A requester must drop or replace its request on the cycle after gnt. The arbiter never grants the same requester in two consecutive cycles, because IDLE always separates grants.
- Non-owner rdata outputs are don't-care; they may mirror mem_rdata.

## Timing
- Reset (async, rst_n=0): state=IDLE, if_wait=0, owner cleared, all gnt/rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. A pending access is dropped and no rvalid is issued after reset.
- Request latency: req high in IDLE at edge N gives ACCESS (gnt, mem_en) in cycle N+1 and, for reads, rvalid in cycle N+2.
- Peak throughput: one access per 2 cycles. An IDLE cycle that overlaps an rvalid may arbitrate the next request.
- Simultaneous requests: data is served first and fetch follows in the next IDLE. A fetch is never delayed by more than MAX_WAIT data grants.
- Requests arriving during ACCESS are not sampled until the next IDLE.
- Address wrap: addresses are AW bits and are passed through with no range check.

## Configuration
- MIPS32_MEMARB_RR_EN defined: round-robin arbitration. A last-owner bit (reset to data) gives the other requester priority when both request. if_wait is not implemented and MAX_WAIT is ignored.
- MIPS32_MEMARB_RR_EN undefined: data-first priority with the starvation guard described above.

## Test plan
- Fetch only: if_addr=5, mem[5]=0x2A000001 -> if_gnt and mem_en with mem_addr=5 in cycle N+1; if_rvalid with if_rdata=0x2A000001 in N+2.
- Store then load: d_we=1, addr=0x3FF, wdata=0xDEADBEEF, then d_we=0, addr=0x3FF -> store shows mem_we=1 and no d_rvalid; load returns d_rdata=0xDEADBEEF.
- Simultaneous fetch/data requests in IDLE -> d_gnt first; if_gnt in the next ACCESS two cycles later.
- Continuous d_req with continuous if_req, MAX_WAIT=3 -> pattern of 3 d_gnt then 1 if_gnt, repeating. With MIPS32_MEMARB_RR_EN the grants strictly alternate.
- rst_n pulled low during ACCESS of a load -> all outputs 0 immediately; no d_rvalid after release; first request after release is granted in 2 cycles.
- Fetch requester holds if_req after if_gnt with a new address -> no grant in the cycle directly after ACCESS overlaps a stale access; the new address is served in the following ACCESS.

Source files
------------

// File: rtl/mips32_mem_arbiter.sv
// Two-port arbiter sharing the single-port unified memory between instruction fetch and data access.
// Default: data-first priority with a fetch starvation guard; define MIPS32_MEMARB_RR_EN for round-robin.
module mips32_mem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          dbg_state_o
);

    // Handshake: a requester holds req (and its address/data) until it sees its
    // gnt pulse; the access is issued in the gnt cycle and read data is valid
    // with rvalid in the following cycle. Requests are sampled only in IDLE.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q;
    logic          owner_d_q;
    logic          if_gnt_q;
    logic          d_gnt_q;
    logic          if_rvalid_q;
    logic          d_rvalid_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          fetch_wins;
    logic          data_wins;

`ifdef MIPS32_MEMARB_RR_EN
    logic last_d_q;

    // On contention the requester that did not own the last access goes first.
    assign fetch_wins = if_req && (!d_req || last_d_q);
`else
    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);
    logic [3:0] if_wait_q;

    assign fetch_wins = if_req && (!d_req || (if_wait_q == MAX_WAIT_L));
`endif
    assign data_wins = d_req && !fetch_wins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MIPS32_MEMARB_RR_EN
            last_d_q    <= 1'b1;
`else
            if_wait_q   <= 4'd0;
`endif
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch_wins || data_wins) begin
                        state_q    <= ACCESS;
                        mem_en_q   <= 1'b1;
                        owner_d_q  <= data_wins;
                        if_gnt_q   <= fetch_wins;
                        d_gnt_q    <= data_wins;
                        mem_addr_q <= fetch_wins ? if_addr : d_addr;
                        mem_we_q   <= data_wins && d_we;
                        if (data_wins) begin
                            mem_wdata_q <= d_wdata;
                        end
`ifdef MIPS32_MEMARB_RR_EN
                        last_d_q   <= data_wins;
`endif
                    end
`ifndef MIPS32_MEMARB_RR_EN
                    if (fetch_wins || !if_req) begin
                        if_wait_q <= 4'd0;
                    end else if (data_wins) begin
                        if_wait_q <= if_wait_q + 4'd1;
                    end
`endif
                end
                ACCESS: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if_gnt_q <= 1'b0;
                    d_gnt_q  <= 1'b0;
                    if (!mem_we_q) begin
                        if_rvalid_q <= !owner_d_q;
                        d_rvalid_q  <= owner_d_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt      = if_gnt_q;
    assign d_gnt       = d_gnt_q;
    assign if_rvalid   = if_rvalid_q;
    assign d_rvalid    = d_rvalid_q;
    // Read data is forced to zero outside its valid pulse so reset leaves every output at 0.
    assign if_rdata    = if_rvalid_q ? mem_rdata : '0;
    assign d_rdata     = d_rvalid_q ? mem_rdata : '0;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = (state_q == ACCESS);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Randomised and directed bench for mips32_mem_arbiter with a transaction-level reference model.
module tb_mips32_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MAX_WAIT = 3;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          dbg_state;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    // Clock and memory
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model state
    int            checks;
    int            errors;
    int            cyc;
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] exp_q[$];
    byte           glog[$];
    int            gcyc[$];
    logic          m_prev_gnt;
    int            m_losses;
    logic          m_last_d;
    logic          rv_if_pend;
    logic          rv_d_pend;
    logic          s_if, s_d, s_we;
    logic [AW-1:0] s_ia, s_da;
    logic [DW-1:0] s_wd;
    logic          g_if, g_d;

    task automatic model_clear();
        m_prev_gnt = 1'b0;
        m_losses   = 0;
        m_last_d   = 1'b1;
        rv_if_pend = 1'b0;
        rv_d_pend  = 1'b0;
        g_if       = 1'b0;
        g_d        = 1'b0;
        exp_q.delete();
    endtask

    // One clock: sample inputs at the rising edge, check outputs at the falling edge.
    task automatic step();
        logic eig, edg, eirv, edrv;
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        @(posedge clk);
        s_if = if_req; s_ia = if_addr; s_d = d_req;
        s_we = d_we;   s_da = d_addr;  s_wd = d_wdata;
        @(negedge clk);
        cyc++;
        eig = 1'b0; edg = 1'b0;
        eirv = rv_if_pend; edrv = rv_d_pend;
        rv_if_pend = 1'b0; rv_d_pend = 1'b0;
        if (!m_prev_gnt) begin
`ifdef MIPS32_MEMARB_RR_EN
            if (s_if && (!s_d || m_last_d)) eig = 1'b1;
            else if (s_d) edg = 1'b1;
`else
            if (s_if && (!s_d || m_losses == MAX_WAIT)) eig = 1'b1;
            else if (s_d) edg = 1'b1;
            if (eig || !s_if) m_losses = 0;
            else m_losses++;
`endif
        end
        if (eig) m_last_d = 1'b0;
        if (edg) m_last_d = 1'b1;
        m_prev_gnt = eig | edg;

        checks++;
        if (if_rvalid !== eirv) begin
            errors++; $display("FAIL if_rvalid cyc %0d got %b exp %b", cyc, if_rvalid, eirv);
        end
        checks++;
        if (d_rvalid !== edrv) begin
            errors++; $display("FAIL d_rvalid cyc %0d got %b exp %b", cyc, d_rvalid, edrv);
        end
        if (eirv || edrv) begin
            ed = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (eirv && if_rdata !== ed) begin
                errors++; $display("FAIL if_rdata cyc %0d got %h exp %h", cyc, if_rdata, ed);
            end
            if (edrv && d_rdata !== ed) begin
                errors++; $display("FAIL d_rdata cyc %0d got %h exp %h", cyc, d_rdata, ed);
            end
        end
        checks++;
        if (if_gnt !== eig) begin
            errors++; $display("FAIL if_gnt cyc %0d got %b exp %b", cyc, if_gnt, eig);
        end
        checks++;
        if (d_gnt !== edg) begin
            errors++; $display("FAIL d_gnt cyc %0d got %b exp %b", cyc, d_gnt, edg);
        end
        checks++;
        if (mem_en !== (eig | edg) || dbg_state !== (eig | edg)) begin
            errors++; $display("FAIL mem_en cyc %0d got %b/%b exp %b", cyc, mem_en, dbg_state, eig | edg);
        end
        if (eig || edg) begin
            ea = eig ? s_ia : s_da;
            checks++;
            if (mem_addr !== ea) begin
                errors++; $display("FAIL mem_addr cyc %0d got %h exp %h", cyc, mem_addr, ea);
            end
            checks++;
            if (mem_we !== (edg && s_we)) begin
                errors++; $display("FAIL mem_we cyc %0d got %b exp %b", cyc, mem_we, edg && s_we);
            end
            if (edg && s_we) begin
                checks++;
                if (mem_wdata !== s_wd) begin
                    errors++; $display("FAIL mem_wdata cyc %0d got %h exp %h", cyc, mem_wdata, s_wd);
                end
            end
        end
        if (eig) begin
            exp_q.push_back(ref_mem[s_ia]);
            rv_if_pend = 1'b1;
        end
        if (edg) begin
            if (s_we) ref_mem[s_da] = s_wd;
            else begin
                exp_q.push_back(ref_mem[s_da]);
                rv_d_pend = 1'b1;
            end
        end
        g_if = if_gnt;
        g_d  = d_gnt;
        if (g_if) begin glog.push_back("F"); gcyc.push_back(cyc); end
        if (g_d)  begin glog.push_back("D"); gcyc.push_back(cyc); end
    endtask

    // Requester drivers: hold until granted, then drop or issue a new request.
    task automatic drive_after(input int p_if, input int p_d);
        int sel;
        if (g_if || !if_req) begin
            if_req  = ($urandom_range(99) < p_if);
            if_addr = AW'($urandom);
        end
        if (g_d || !d_req) begin
            d_req   = ($urandom_range(99) < p_d);
            d_we    = $urandom_range(1);
            sel     = $urandom_range(3);
            d_addr  = (sel == 0) ? 10'h3FF : (sel == 1) ? 10'h000 : AW'($urandom_range(15));
            d_wdata = $urandom;
        end
    endtask

    task automatic idle(input int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000",
                               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || dbg_state !== 1'b0) begin
            errors++; $display("FAIL reset_mem got %h/%h/%b exp 0", mem_addr, mem_wdata, dbg_state);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_fetch_only();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd5; d_wdata = 32'h2A000001;
        step();
        d_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 10'd5;
        step();
        checks++;
        if (if_gnt !== 1'b1 || mem_addr !== 10'd5) begin
            errors++; $display("FAIL fetch_gnt got %b/%h exp 1/005", if_gnt, mem_addr);
        end
        if_req = 1'b0;
        step();
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h2A000001) begin
            errors++; $display("FAIL fetch_data got %b/%h exp 1/2a000001", if_rvalid, if_rdata);
        end
        idle(1);
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 32'hDEADBEEF;
        step();
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin
            errors++; $display("FAIL store_gnt got %b/%b exp 1/1", d_gnt, mem_we);
        end
        d_req = 1'b0;
        step();
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_rvalid got %b exp 0", d_rvalid);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
        step();
        d_req = 1'b0;
        step();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_data got %b/%h exp 1/deadbeef", d_rvalid, d_rdata);
        end
        idle(1);
    endtask

    task automatic test_simultaneous();
        idle(2);
        glog.delete(); gcyc.delete();
        if_req = 1'b1; if_addr = 10'h040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            step();
            if (g_if) if_req = 1'b0;
            if (g_d)  d_req = 1'b0;
        end
        checks++;
`ifdef MIPS32_MEMARB_RR_EN
        if (glog.size() != 2 || glog[0] != "F" || glog[1] != "D" || gcyc[1] - gcyc[0] != 2) begin
`else
        if (glog.size() != 2 || glog[0] != "D" || glog[1] != "F" || gcyc[1] - gcyc[0] != 2) begin
`endif
            errors++; $display("FAIL simultaneous got %0d grants first %c exp two grants 2 cycles apart",
                               glog.size(), (glog.size() > 0) ? glog[0] : "-");
        end
        idle(2);
    endtask

    task automatic test_starvation();
        string got;
        idle(2);
        glog.delete(); gcyc.delete();
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            drive_after(100, 100);
        end
        got = "";
        foreach (glog[i]) got = {got, string'(glog[i])};
        checks++;
`ifdef MIPS32_MEMARB_RR_EN
        begin
            bit alt;
            alt = (glog.size() == 8);
            for (int i = 1; i < glog.size(); i++) if (glog[i] == glog[i-1]) alt = 1'b0;
            if (!alt) begin
                errors++; $display("FAIL rr_alternate got %s exp alternating 8 grants", got);
            end
        end
`else
        if (got != "DDDFDDDF") begin
            errors++; $display("FAIL starvation got %s exp DDDFDDDF", got);
        end
`endif
        idle(2);
    endtask

    task automatic test_reset_during_access();
        idle(2);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h02A;
        step();
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_access_gnt got %b exp 1", d_gnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("FAIL rst_outputs got %b %h %h %h %h exp all 0",
                               {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we},
                               mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        d_req = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3FF;
        step();
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_first_gnt got %b exp 1", d_gnt);
        end
        d_req = 1'b0;
        idle(2);
    endtask

    task automatic test_back_to_back();
        int n;
        idle(2);
        if_req = 1'b1; if_addr = 10'h100;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (g_if) n++;
            drive_after(100, 0);
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL back_to_back got %0d fetch grants exp 4", n);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            step();
            drive_after(55, 55);
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL random_drain got %0d pending exp 0", exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_fetch_only();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_reset_during_access();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
